// File: rtl/fib_pkg.sv
// Shared types and seed constants for the additive-sequence generator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic {
    MODE_FIB   = 1'b0,
    MODE_LUCAS = 1'b1
  } mode_e;

  localparam int FIB_SEED0   = 0;
  localparam int FIB_SEED1   = 1;
  localparam int LUCAS_SEED0 = 2;
  localparam int LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_seq_gen.sv
// Iterative Fibonacci/Lucas term generator with start/done handshake and exact overflow flag.
// Optional per-term streaming ports are enabled by defining FIB_STREAM_EN.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] din,
  input  logic                 mode,
  output logic [WIDTH-1:0]     dout,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow
`ifdef FIB_STREAM_EN
  ,
  output logic                 term_valid,
  output logic [WIDTH-1:0]     term_out
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 a_ovf_q, a_ovf_d;
  logic                 b_ovf_q, b_ovf_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH:0]       sum;
  logic                 accept;
  mode_e                mode_sel;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign mode_sel = mode_e'(mode);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (start) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = (mode_sel == MODE_LUCAS) ? WIDTH'(LUCAS_SEED0) : WIDTH'(FIB_SEED0);
      b_d     = (mode_sel == MODE_LUCAS) ? WIDTH'(LUCAS_SEED1) : WIDTH'(FIB_SEED1);
      cnt_d   = din;
      a_ovf_d = 1'b0;
      b_ovf_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == CALC) begin
      if (cnt_q == '0) begin
        dout_d = a_q;
        ovf_d  = a_ovf_q;
      end else begin
        // Overflow travels with its value, so a carry in b only matters if b becomes term n.
        a_d     = b_q;
        b_d     = sum[WIDTH-1:0];
        a_ovf_d = b_ovf_q;
        b_ovf_d = a_ovf_q | b_ovf_q | sum[WIDTH];
        cnt_d   = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    busy     = (state_q == CALC);
    done     = (state_q == DONE);
    dout     = dout_q;
    overflow = ovf_q;
`ifdef FIB_STREAM_EN
    term_valid = (state_q == CALC);
    term_out   = (state_q == CALC) ? a_q : '0;
`endif
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed self-checking bench for fib_seq_gen (WIDTH=16, IDX_WIDTH=16).
module tb_fib_seq_gen;

  localparam int WIDTH     = 16;
  localparam int IDX_WIDTH = 16;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic [IDX_WIDTH-1:0] din;
  logic                 mode;
  logic [WIDTH-1:0]     dout;
  logic                 done;
  logic                 busy;
  logic                 overflow;
`ifdef FIB_STREAM_EN
  logic                 term_valid;
  logic [WIDTH-1:0]     term_out;
  logic [WIDTH-1:0]     stream_q[$];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fib_seq_gen #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .din      (din),
    .mode     (mode),
    .dout     (dout),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
`ifdef FIB_STREAM_EN
    ,
    .term_valid (term_valid),
    .term_out   (term_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIB_STREAM_EN
  always @(negedge clk) if (term_valid) stream_q.push_back(term_out);
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch at the next edge and wait for done; checks latency, busy, result and flag.
  task automatic run(input string tag, input int n, input logic m,
                     input int exp_dout, input logic exp_ovf);
    int cycles;
    int busy_bad;
    @(negedge clk);
    start = 1'b1;
    din   = IDX_WIDTH'(n);
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " done_low_after_start"}, 32'(done), 32'd0);
    cycles   = 0;
    busy_bad = 0;
    while (!done && cycles < 300) begin
      if (!busy) busy_bad++;
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'(n + 1));
    check({tag, " busy_during_calc"}, 32'(busy_bad), 32'd0);
    check({tag, " dout"}, 32'(dout), 32'(exp_dout));
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, " busy_after_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cycles;
    start   = 1'b0;
    din     = '0;
    mode    = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset dout", 32'(dout), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run("fib0", 0, 1'b0, 0, 1'b0);
    run("fib1", 1, 1'b0, 1, 1'b0);
    run("fib2", 2, 1'b0, 1, 1'b0);
`ifdef FIB_STREAM_EN
    stream_q.delete();
`endif
    run("fib6", 6, 1'b0, 8, 1'b0);
`ifdef FIB_STREAM_EN
    begin
      logic [WIDTH-1:0] exp_terms[7] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
      check("stream count", 32'(stream_q.size()), 32'd7);
      for (int i = 0; i < 7; i++)
        if (i < stream_q.size()) check($sformatf("stream term%0d", i), 32'(stream_q[i]), 32'(exp_terms[i]));
    end
`endif
    run("luc0", 0, 1'b1, 2, 1'b0);
    run("luc1", 1, 1'b1, 1, 1'b0);
    run("luc5", 5, 1'b1, 11, 1'b0);
    run("fib24", 24, 1'b0, 46368, 1'b0);
    run("fib25", 25, 1'b0, 9489, 1'b1);

    // Second start three cycles into a run must be ignored.
    @(negedge clk);
    start = 1'b1;
    din   = 16'd10;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    din   = 16'd3;
    mode  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignore busy", 32'(busy), 32'd1);
    cycles = 3;
    while (!done && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("ignore latency", 32'(cycles), 32'd11);
    check("ignore dout", 32'(dout), 32'd55);
    check("ignore overflow", 32'(overflow), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("done hold dout", 32'(dout), 32'd55);
    check("done hold done", 32'(done), 32'd1);

    run("relaunch3", 3, 1'b0, 2, 1'b0);

    // Asynchronous reset mid-computation aborts and clears outputs immediately.
    @(negedge clk);
    start = 1'b1;
    din   = 16'd20;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort dout", 32'(dout), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run("post_reset fib5", 5, 1'b0, 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
